tile_lane_queue: RTL

//  Per-lane falling-tile engine: the parametrised successor of the single moving

---
 rtl/tile_lane_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/tile_lane_queue.sv
// Per-lane falling-tile engine. Tiles live in a circular queue (head = oldest,
// lowest on screen). Every frame edge: judge a key press against the head, drop a
// head that falls off screen, move survivors down by `speed`, then accept a spawn.
module tile_lane_queue #(
    parameter int DEPTH   = 4,
    parameter int SPEED_W = 4,
    parameter int Y_START = 0,
    parameter int Y_MAX   = 479,
    parameter int TILE_H  = 75,
    parameter int HIT_TOP = 380,
    parameter int HIT_BOT = 479
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic                     spawn,
    input  logic                     key_hit,
    input  logic [SPEED_W-1:0]       speed,
    output logic [10*DEPTH-1:0]      tile_y,
    output logic [DEPTH-1:0]         tile_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     hit_ok,
    output logic                     miss,
    output logic                     overflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [9:0]    y_q [DEPTH];
    logic [9:0]    y_mv [DEPTH];
    logic [IW-1:0] head_q;
    logic [IW-1:0] tail_q;

    logic [9:0]    yh;
    logic          head_valid;
    logic          in_window;
    logic          hit_pop;
    logic          key_miss;
    logic          fall_pop;
    logic          pop;
    logic [CW-1:0] occ_after;
    logic          do_spawn;
    logic          drop_spawn;

    // Flatten slot Y registers onto the renderer bus.
    always_comb begin
        tile_y = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tile_y[10*i +: 10] = y_q[i];
        end
    end

    // Next Y for every slot if it moves; saturates instead of wrapping.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [10:0] sum;
            sum     = {1'b0, y_q[i]} + 11'(speed);
            y_mv[i] = sum[10] ? 10'h3FF : sum[9:0];
        end
    end

    // Per-edge decisions, all taken on the pre-edge state of the head tile.
    always_comb begin
        yh         = y_q[head_q];
        head_valid = tile_valid[head_q];
        in_window  = (({1'b0, yh} + 11'(TILE_H - 1)) >= 11'(HIT_TOP)) &&
                     (yh <= 10'(HIT_BOT));
        hit_pop    = key_hit && head_valid && in_window;
        key_miss   = key_hit && !hit_pop;
        fall_pop   = head_valid && !hit_pop &&
                     (({1'b0, yh} + 11'(speed)) > 11'(Y_MAX));
        pop        = hit_pop || fall_pop;
        occ_after  = count - CW'(pop);
        do_spawn   = spawn && (occ_after < CW'(DEPTH));
        drop_spawn = spawn && !do_spawn;
    end

    // Queue state and result pulses; spawn is written last so that a full lane
    // popping and spawning on one edge reuses the freed head slot.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                y_q[i] <= '0;
            end
            tile_valid <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count      <= '0;
            hit_ok     <= 1'b0;
            miss       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            hit_ok   <= hit_pop;
            miss     <= key_miss || fall_pop;
            overflow <= drop_spawn;
            for (int i = 0; i < DEPTH; i++) begin
                if (tile_valid[i] && !(pop && (IW'(i) == head_q))) begin
                    y_q[i] <= y_mv[i];
                end
            end
            if (pop) begin
                tile_valid[head_q] <= 1'b0;
                head_q             <= head_q + IW'(1);
            end
            if (do_spawn) begin
                y_q[tail_q]        <= 10'(Y_START);
                tile_valid[tail_q] <= 1'b1;
                tail_q             <= tail_q + IW'(1);
            end
            count <= count - CW'(pop) + CW'(do_spawn);
        end
    end

endmodule
